gpr_mp: RTL and testbench



---
 rtl/gpr_pkg.sv | 44 ++++
 rtl/gpr_scoreboard.sv | 51 +++++
 rtl/gpr_mp.sv | 79 +++++++
 tb/tb_gpr_mp.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
`default_nettype none
// gpr_pkg: shared constants, ABI register indices and write-port priority helper for gpr_mp.
// Rev 1.0
package gpr_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int MAX_WR     = 2;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd1;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;
  localparam logic [REG_ADDR_W-1:0] REG_GP   = 5'd3;
  localparam logic [REG_ADDR_W-1:0] REG_TP   = 5'd4;
  localparam logic [REG_ADDR_W-1:0] REG_T0   = 5'd5;
  localparam logic [REG_ADDR_W-1:0] REG_T1   = 5'd6;
  localparam logic [REG_ADDR_W-1:0] REG_T2   = 5'd7;
  localparam logic [REG_ADDR_W-1:0] REG_S0   = 5'd8;
  localparam logic [REG_ADDR_W-1:0] REG_S1   = 5'd9;
  localparam logic [REG_ADDR_W-1:0] REG_A0   = 5'd10;
  localparam logic [REG_ADDR_W-1:0] REG_A1   = 5'd11;

  typedef struct packed {
    logic hit;
    logic idx;
  } wr_sel_t;

  // Later ports overwrite earlier matches, so the highest-index port wins.
  function automatic wr_sel_t wr_select(input logic [MAX_WR-1:0]            en,
                                        input logic [MAX_WR*REG_ADDR_W-1:0] addr,
                                        input logic [REG_ADDR_W-1:0]        tgt);
    wr_sel_t s;
    s = '0;
    for (int w = 0; w < MAX_WR; w++) begin
      if (en[w] && (tgt != REG_ZERO) && (addr[w*REG_ADDR_W +: REG_ADDR_W] == tgt)) begin
        s.hit = 1'b1;
        s.idx = w[0];
      end
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_scoreboard.sv
`default_nettype none
// gpr_scoreboard: per-register busy bits, reservation beats writeback clear.
// Rev 1.0
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [MAX_WR-1:0]              wr_en,
  input  logic [MAX_WR*REG_ADDR_W-1:0]   wr_addr,
  input  logic                           rsv_en,
  input  logic [REG_ADDR_W-1:0]          rsv_addr,
  input  logic [NUM_RD*REG_ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD-1:0]              rd_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  wr_sel_t             wsel [NUM_REGS];

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_wsel
    assign wsel[r] = wr_select(wr_en, wr_addr, REG_ADDR_W'(r));
  end

  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (wsel[r].hit) busy_nxt[r] = 1'b0;
      if (rsv_en && (rsv_addr == REG_ADDR_W'(r))) busy_nxt[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [REG_ADDR_W-1:0] a;
    wr_sel_t               byp;
    assign a   = rd_addr[p*REG_ADDR_W +: REG_ADDR_W];
    assign byp = wr_select(wr_en, wr_addr, a);
    // A bypassed write retires the old producer; only a same-cycle new reservation keeps it busy.
    assign rd_busy[p] = (BYPASS != 0 && byp.hit) ? (rsv_en && (rsv_addr == a)) : busy[a];
  end

endmodule
`default_nettype wire

// File: rtl/gpr_mp.sv
`default_nettype none
// gpr_mp: parametrised multi-port GPR file with x0 hardwired to zero, optional bypass and busy scoreboard.
// Rev 1.0
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RD*REG_ADDR_W-1:0]  rAddr,
  output logic [NUM_RD*XLEN-1:0]        rData,
  output logic [NUM_RD-1:0]             rBusy,
  input  logic [NUM_WR-1:0]             wEn,
  input  logic [NUM_WR*REG_ADDR_W-1:0]  wAddr,
  input  logic [NUM_WR*XLEN-1:0]        wData,
  input  logic                          rsvEn,
  input  logic [REG_ADDR_W-1:0]         rsvAddr
);

  if (NUM_RD < 1 || NUM_RD > 4 || NUM_WR < 1 || NUM_WR > MAX_WR ||
      (BYPASS != 0 && BYPASS != 1) || XLEN < 1) begin : g_param_err
    $error("gpr_mp: parameter out of range");
  end

  logic [MAX_WR-1:0]            wen_live;
  logic [MAX_WR*REG_ADDR_W-1:0] waddr_pad;
  logic [MAX_WR*XLEN-1:0]       wdata_pad;
  logic [XLEN-1:0]              regs [NUM_REGS];
  wr_sel_t                      wsel [NUM_REGS];

  // Write enables are masked by reset so bypass never leaks data while the array is held clear.
  assign wen_live  = MAX_WR'(wEn) & {MAX_WR{rst_n}};
  assign waddr_pad = (MAX_WR*REG_ADDR_W)'(wAddr);
  assign wdata_pad = (MAX_WR*XLEN)'(wData);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_wsel
    assign wsel[r] = wr_select(wen_live, waddr_pad, REG_ADDR_W'(r));
  end

  // regs[0] is only ever cleared, so it folds to a constant zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wsel[r].hit) regs[r] <= wdata_pad[wsel[r].idx*XLEN +: XLEN];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [REG_ADDR_W-1:0] a;
    wr_sel_t               byp;
    assign a   = rAddr[p*REG_ADDR_W +: REG_ADDR_W];
    assign byp = wr_select(wen_live, waddr_pad, a);
    assign rData[p*XLEN +: XLEN] = (BYPASS != 0 && byp.hit) ? wdata_pad[byp.idx*XLEN +: XLEN]
                                                             : regs[a];
  end

  gpr_scoreboard #(
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wen_live),
    .wr_addr  (waddr_pad),
    .rsv_en   (rsvEn),
    .rsv_addr (rsvAddr),
    .rd_addr  (rAddr),
    .rd_busy  (rBusy)
  );

endmodule
`default_nettype wire

// File: tb/tb_gpr_mp.sv
`default_nettype none
// tb_gpr_mp: scoreboard bench for a bypassing 2R/2W instance and a non-bypassing 1R/1W instance.
// Rev 1.0
module tb_gpr_mp;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   raddr;
  logic [1:0]   we;
  logic [9:0]   wa;
  logic [127:0] wd;
  logic         rsv_en;
  logic [4:0]   rsv_addr;
  logic [127:0] rdata;
  logic [1:0]   rbusy;
  logic [63:0]  nb_rdata;
  logic [0:0]   nb_rbusy;

  always #5 clk = ~clk;

  gpr_mp #(.XLEN(64), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rAddr(raddr), .rData(rdata), .rBusy(rbusy),
    .wEn(we), .wAddr(wa), .wData(wd), .rsvEn(rsv_en), .rsvAddr(rsv_addr)
  );

  gpr_mp #(.XLEN(64), .NUM_RD(1), .NUM_WR(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rAddr(raddr[4:0]), .rData(nb_rdata), .rBusy(nb_rbusy),
    .wEn(we[0:0]), .wAddr(wa[4:0]), .wData(wd[63:0]), .rsvEn(rsv_en), .rsvAddr(rsv_addr)
  );

  logic [63:0] m_regs [32];
  logic [31:0] m_busy;
  logic [63:0] n_regs [32];
  logic [31:0] n_busy;

  typedef struct packed {
    logic [2:0][63:0] d;
    logic [2:0]       b;
  } exp_t;

  exp_t  sb_q [$];
  string tag_q [$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_reset(input logic v);
    rst_n = v;
    if (!v) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        n_regs[r] = '0;
      end
      m_busy = '0;
      n_busy = '0;
    end
  endtask

  task automatic idle();
    we     = '0;
    rsv_en = 1'b0;
  endtask

  task automatic check_cycle(input string tag);
    exp_t        e;
    logic [4:0]  a;
    e = '0;
    for (int p = 0; p < 2; p++) begin
      a = raddr[p*5 +: 5];
      e.d[p] = m_regs[a];
      e.b[p] = m_busy[a];
      if (rst_n && a != 5'd0) begin
        for (int w = 0; w < 2; w++) begin
          if (we[w] && wa[w*5 +: 5] == a) begin
            e.d[p] = wd[w*64 +: 64];
            e.b[p] = rsv_en && (rsv_addr == a);
          end
        end
      end
      if (!rst_n || a == 5'd0) begin
        e.d[p] = '0;
        e.b[p] = 1'b0;
      end
    end
    a = raddr[4:0];
    e.d[2] = n_regs[a];
    e.b[2] = n_busy[a];
    sb_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    begin
      exp_t  x;
      string t;
      x = sb_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".d0"}, rdata[63:0],   x.d[0]);
      chk({t, ".d1"}, rdata[127:64], x.d[1]);
      chk({t, ".dn"}, nb_rdata,      x.d[2]);
      chk({t, ".b0"}, 64'(rbusy[0]), 64'(x.b[0]));
      chk({t, ".b1"}, 64'(rbusy[1]), 64'(x.b[1]));
      chk({t, ".bn"}, 64'(nb_rbusy), 64'(x.b[2]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int w = 0; w < 2; w++) begin
        if (we[w] && wa[w*5 +: 5] != 5'd0) begin
          m_regs[wa[w*5 +: 5]] = wd[w*64 +: 64];
          m_busy[wa[w*5 +: 5]] = 1'b0;
        end
      end
      if (we[0] && wa[4:0] != 5'd0) begin
        n_regs[wa[4:0]] = wd[63:0];
        n_busy[wa[4:0]] = 1'b0;
      end
      if (rsv_en && rsv_addr != 5'd0) begin
        m_busy[rsv_addr] = 1'b1;
        n_busy[rsv_addr] = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    raddr    = '0;
    wa       = '0;
    wd       = '0;
    rsv_addr = '0;
    set_reset(1'b0);
    #1;
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      check_cycle("reset_sweep");
    end
    tick();
    set_reset(1'b1);

    we = 2'b01; wa = {5'd0, 5'd5}; wd = {64'd0, 64'h1234}; raddr = '0;
    check_cycle("wr_x5");
    tick(); idle();
    raddr = {5'd0, 5'd5};
    check_cycle("rd_x5");
    chk("x5_before_rst", rdata[63:0], 64'h1234);
    set_reset(1'b0);
    check_cycle("async_rst");
    chk("x5_async_rst", rdata[63:0], 64'h0);
    tick();
    set_reset(1'b1);

    we = 2'b01; wa = {5'd0, 5'd7}; wd = {64'd0, 64'hDEADBEEF_CAFEF00D};
    tick(); idle();
    raddr = {5'd7, 5'd7};
    check_cycle("rd_x7");
    chk("x7_p0", rdata[63:0],   64'hDEADBEEF_CAFEF00D);
    chk("x7_p1", rdata[127:64], 64'hDEADBEEF_CAFEF00D);

    we = 2'b01; wa = {5'd0, 5'd0}; wd = {64'd0, {64{1'b1}}}; raddr = '0;
    check_cycle("wr_x0");
    chk("x0_same_cycle", rdata[63:0], 64'h0);
    tick(); idle();
    check_cycle("rd_x0");
    chk("x0_after", rdata[63:0], 64'h0);

    we = 2'b01; wa = {5'd0, 5'd9}; wd = {64'd0, 64'h55}; raddr = {5'd0, 5'd9};
    check_cycle("bypass");
    chk("bypass_on", rdata[63:0], 64'h55);
    chk("bypass_off_old", nb_rdata, 64'h0);
    tick(); idle();
    check_cycle("bypass_next");
    chk("bypass_off_new", nb_rdata, 64'h55);

    we = 2'b11; wa = {5'd3, 5'd3}; wd = {64'h22, 64'h11}; raddr = {5'd3, 5'd3};
    check_cycle("dual_wr");
    tick(); idle();
    check_cycle("dual_rd");
    chk("x3_port1_wins", rdata[63:0], 64'h22);

    rsv_en = 1'b1; rsv_addr = 5'd12; raddr = {5'd12, 5'd12};
    check_cycle("rsv12");
    chk("rsv_not_yet", 64'(rbusy[0]), 64'd0);
    tick(); idle();
    check_cycle("rsv12_busy");
    chk("rsv_busy", 64'(rbusy[0]), 64'd1);
    we = 2'b01; wa = {5'd0, 5'd12}; wd = {64'd0, 64'h99};
    check_cycle("wr12");
    tick(); idle();
    check_cycle("wr12_after");
    chk("wr12_busy", 64'(rbusy[0]), 64'd0);
    chk("wr12_data", rdata[63:0], 64'h99);
    we = 2'b01; wa = {5'd0, 5'd12}; wd = {64'd0, 64'h77}; rsv_en = 1'b1; rsv_addr = 5'd12;
    check_cycle("wr_rsv12");
    tick(); idle();
    check_cycle("wr_rsv12_after");
    chk("wr_rsv12_busy", 64'(rbusy[0]), 64'd1);
    chk("wr_rsv12_data", rdata[63:0], 64'h77);
    rsv_en = 1'b1; rsv_addr = 5'd0; raddr = '0;
    tick(); idle();
    check_cycle("rsv_x0");
    chk("rsv_x0_busy", 64'(rbusy[0]), 64'd0);

    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 99) == 0) set_reset(1'b0);
      else if (!rst_n)                set_reset(1'b1);
      we       = 2'($urandom);
      wa       = {rand_addr(), rand_addr()};
      wd       = {$urandom, $urandom, $urandom, $urandom};
      rsv_en   = ($urandom_range(0, 3) == 0);
      rsv_addr = rand_addr();
      raddr    = {rand_addr(), rand_addr()};
      check_cycle("random");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
